uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts one even-parity bit after the data bits.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tx_data  input  8  byte to send; sampled only on handshake.
REQ-007 tx_valid  input  1  requester has a byte on tx_data.
REQ-008 tx_ready  output  1  controller can accept a byte this cycle.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  high while a frame is being sent (START through STOP).

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-012 tx_ready SHALL be 1 exactly when the state is IDLE and rst is low; it is combinational from state.
REQ-013 A handshake SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data is latched into a shift register at that edge and the state moves to START.
REQ-014 tx_valid while not IDLE SHALL be ignored; no byte is latched and no error is flagged.
REQ-015 tx and busy SHALL be registered outputs: tx=0 and busy=1 take effect on the edge that performs the handshake, i.e. they are visible in the cycle after acceptance.
REQ-016 Each of START, each DATA bit, PARITY and each STOP bit SHALL hold tx constant for exactly CLKS_PER_BIT cycles.
REQ-017 START drives tx=0; DATA drives bits LSB first, bit 0..7, using a 3-bit bit index that advances on each bit-period end; PARITY drives the XOR of the latched byte; STOP drives tx=1.
REQ-018 DATA SHALL leave on the bit-period end with bit index 7, to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-019 STOP SHALL last STOP_BITS bit periods, then return to IDLE; busy drops on that same edge.
REQ-020 The minimum inter-frame gap SHALL be one IDLE cycle: a handshake cannot occur in the last STOP cycle.
REQ-021 Frame length (busy high) SHALL be CLKS_PER_BIT*(9+PARITY_EN+STOP_BITS) cycles.
REQ-022 Changes to tx_data after the handshake SHALL not affect the frame in progress.
REQ-023 The bit-period counter SHALL be 16 bits wide, count 0..CLKS_PER_BIT-1, and restart at 0 at the handshake and at every bit-period end.

Reset
REQ-024 With rst high on an edge, the next state SHALL be: IDLE, tx=1, busy=0, counter=0, bit index=0, shift register=0.
REQ-025 rst mid-frame SHALL abort the frame at that edge; tx returns high and the partial byte is discarded without retransmission.
REQ-026 A handshake SHALL be blocked on any edge where rst is high, even if tx_valid=1.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding (typedef, 3-bit) and the constant DATA_BITS=8.
REQ-028 The bit-period counter SHALL be a sub-module, baud_tick, with inputs clk_in, rst and restart, and output tick, which pulses one cycle at count CLKS_PER_BIT-1.
REQ-029 No other sub-modules are permitted; the FSM, shift register and parity SHALL be implemented in uart_tx_ctrl.

Verification
REQ-030 Single byte: CLKS_PER_BIT=10, send 0x55 -> tx = 0, then 1,0,1,0,1,0,1,0, then 1, each bit 10 cycles; busy high for 100 cycles.
REQ-031 Parity: PARITY_EN=1, send 0x07 -> parity bit 1; with 0x03 -> 0; busy high for 110 cycles.
REQ-032 Back-to-back: tx_valid held high with 0xA5 then 0x3C -> exactly one IDLE cycle with tx_ready=1 between the frames; the second frame decodes to 0x3C.
REQ-033 Busy ignore: pulse tx_valid with 0xFF mid-frame -> no acceptance; the current frame is unchanged and no extra frame follows.
REQ-034 Reset mid-frame: assert rst at cycle 35 of a 0x00 frame -> tx=1, busy=0, tx_ready=1 the next cycle; the next send of 0x81 is correct.
REQ-035 STOP_BITS=2, CLKS_PER_BIT=2: send 0xC3 -> stop high for 4 cycles; busy high for 22 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit controller.
//   state_t     - 3-bit FSM state encoding
//   DATA_BITS   - payload width of one frame
//   CNT_W       - width of the bit-period counter
//   IDX_W       - width of the data bit index
//   even_parity - parity bit that makes the count of ones even
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // XOR of all data bits; appended after the data to give even parity
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// baud_tick: bit-period counter for the UART transmitter.
//   clk_in  - clock, rising edge
//   rst     - synchronous active-high reset, clears the counter
//   restart - forces the counter back to 0 (frame start)
//   tick    - high for one cycle while the count is CLKS_PER_BIT-1
module baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk_in,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Counts 0..CLKS_PER_BIT-1 and wraps, so every bit-period end restarts at 0
  always_ff @(posedge clk_in) begin
    if (rst || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller, 8 data bits, optional even parity,
// one or two stop bits, LSB first.
//   clk_in   - clock, rising edge
//   rst      - synchronous active-high reset; aborts any frame in progress
//   tx_data  - byte to send, sampled on the handshake edge only
//   tx_valid - requester has a byte on tx_data
//   tx_ready - combinational: controller is idle and not in reset
//   tx       - registered serial line, idle high
//   busy     - registered, high from START through the last STOP cycle
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 parity_bit;
  logic                 stop_cnt;
  logic                 tick;
  logic                 handshake;

  assign tx_ready  = (state == ST_IDLE) && !rst;
  assign handshake = tx_valid && tx_ready;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .restart(handshake),
    .tick   (tick)
  );

  // Frame sequencer; tx always carries the level of the state being entered
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            shift_reg  <= tx_data;
            parity_bit <= even_parity(tx_data);
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            tx    <= shift_reg[0];
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              // bit 1 becomes the next bit on the line once shifted down
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + IDX_W'(1);
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with three configurations:
//   inst 0: 10 clks/bit, no parity, 1 stop
//   inst 1: 10 clks/bit, even parity, 1 stop
//   inst 2: 2 clks/bit, no parity, 2 stops
module tb_uart_tx_ctrl;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] valid_v;
  logic [7:0] data;
  logic [2:0] ready_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(10), .PARITY_EN(0), .STOP_BITS(1)) u_std (
    .clk_in(clk), .rst(rst_v[0]), .tx_data(data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(10), .PARITY_EN(1), .STOP_BITS(1)) u_par (
    .clk_in(clk), .rst(rst_v[1]), .tx_data(data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) u_two (
    .clk_in(clk), .rst(rst_v[2]), .tx_data(data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a byte for one handshake edge on instance idx
  task automatic start(input int idx, input logic [7:0] b);
    data = b;
    valid_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    valid_v[idx] = 1'b0;
  endtask

  // Sample one frame at negedges while busy; bits[k] is the level at the
  // first cycle of bit period k, gl counts level changes inside a period.
  // pulse_at >= 0 drives a 3-cycle tx_valid pulse with 0xFF mid-frame.
  task automatic capture(input int idx, input int cpb, input int pulse_at,
                         output int blen, output logic [15:0] bits, output int gl);
    blen = 0;
    bits = '0;
    gl   = 0;
    @(negedge clk);
    while (busy_v[idx] && blen < 400) begin
      if (pulse_at >= 0 && blen == pulse_at) begin
        data = 8'hFF;
        valid_v[idx] = 1'b1;
      end
      if (pulse_at >= 0 && blen == pulse_at + 3) valid_v[idx] = 1'b0;
      if (blen / cpb < 16) begin
        if (blen % cpb == 0) bits[blen / cpb] = tx_v[idx];
        else if (tx_v[idx] != bits[blen / cpb]) gl++;
      end
      blen++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          blen;
    int          gl;
    int          n;
    logic [15:0] bits;

    rst_v   = 3'b111;
    valid_v = 3'b000;
    data    = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst", 32'(ready_v[0]), 0);
    chk("tx_in_rst", 32'(tx_v[0]), 1);
    @(posedge clk);
    #1;
    rst_v = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(tx_v[i]), 1);
      chk($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 0);
      chk($sformatf("rst_ready%0d", i), 32'(ready_v[i]), 1);
    end

    // Single byte 0x55: 0,1,0,1,0,1,0,1,0,1
    start(0, 8'h55);
    capture(0, 10, -1, blen, bits, gl);
    chk("frame_55", 32'(bits), 32'h02AA);
    chk("len_55", blen, 100);
    chk("glitch_55", gl, 0);
    chk("idle_ready_55", 32'(ready_v[0]), 1);
    chk("idle_tx_55", 32'(tx_v[0]), 1);

    // Busy ignore: 0xFF offered mid-frame must not be taken
    start(0, 8'h96);
    capture(0, 10, 40, blen, bits, gl);
    chk("frame_96", 32'(bits), 32'h032C);
    chk("len_96", blen, 100);
    chk("glitch_96", gl, 0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_v[0]) n++;
    end
    chk("no_extra_frame", n, 0);

    // Back-to-back with tx_valid held high
    data = 8'hA5;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    data = 8'h3C;
    capture(0, 10, -1, blen, bits, gl);
    chk("frame_a5", 32'(bits), 32'h034A);
    chk("len_a5", blen, 100);
    chk("gap_ready", 32'(ready_v[0]), 1);
    chk("gap_busy", 32'(busy_v[0]), 0);
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    capture(0, 10, -1, blen, bits, gl);
    chk("frame_3c", 32'(bits), 32'h0278);
    chk("len_3c", blen, 100);

    // Reset mid-frame of 0x00, then a clean 0x81
    start(0, 8'h00);
    repeat (35) @(negedge clk);
    chk("mid_busy", 32'(busy_v[0]), 1);
    chk("mid_tx", 32'(tx_v[0]), 0);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_tx", 32'(tx_v[0]), 1);
    chk("abort_busy", 32'(busy_v[0]), 0);
    chk("abort_ready", 32'(ready_v[0]), 1);
    start(0, 8'h81);
    capture(0, 10, -1, blen, bits, gl);
    chk("frame_81", 32'(bits), 32'h0302);
    chk("len_81", blen, 100);

    // Handshake blocked while rst is high
    @(negedge clk);
    rst_v[1] = 1'b1;
    valid_v[1] = 1'b1;
    data = 8'h07;
    @(posedge clk);
    #1;
    rst_v[1] = 1'b0;
    valid_v[1] = 1'b0;
    @(negedge clk);
    chk("rst_block_busy", 32'(busy_v[1]), 0);
    chk("rst_block_tx", 32'(tx_v[1]), 1);

    // Parity: 0x07 -> parity 1, 0x03 -> parity 0
    start(1, 8'h07);
    capture(1, 10, -1, blen, bits, gl);
    chk("frame_p07", 32'(bits), 32'h060E);
    chk("len_p07", blen, 110);
    chk("glitch_p07", gl, 0);
    start(1, 8'h03);
    capture(1, 10, -1, blen, bits, gl);
    chk("frame_p03", 32'(bits), 32'h0406);
    chk("len_p03", blen, 110);

    // Two stop bits, 2 clks/bit: 0xC3
    start(2, 8'hC3);
    capture(2, 2, -1, blen, bits, gl);
    chk("frame_c3", 32'(bits), 32'h0786);
    chk("len_c3", blen, 22);
    chk("glitch_c3", gl, 0);
    chk("idle_tx_c3", 32'(tx_v[2]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
